// File: rtl/axi_arb_pkg.sv
// Shared types and sizing helpers for the axi_user_arbiter slice.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned BLEN_W     = 4;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Width of a counter that spans 0 .. limit-1.
  function automatic int unsigned tmo_cnt_w(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/axi_user_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; first set request at or after ptr wins.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   win
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_user_arbiter.sv
// Round-robin sharing of the axi_master_fsm user-command port, one transaction in flight.
// Optional watchdog: define AXI_ARB_TIMEOUT_EN.
module axi_user_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
  input  logic [NUM_REQ*BLEN_W-1:0]     req_blen,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic                          rsp_err,
  output logic                          U_WVALID,
  output logic                          U_RVALID,
  output logic [ADDR_W-1:0]             U_AWADDR,
  output logic [ADDR_W-1:0]             U_ARADDR,
  output logic [DATA_W-1:0]             U_WDATA,
  output logic [DATA_W/8-1:0]           U_STRB,
  output logic [BLEN_W-1:0]             U_BLEN,
  input  logic [DATA_W-1:0]             U_RDATA,
  input  logic                          U_RDATA_VALID,
  input  logic                          U_DONE
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e          state, state_n;
  logic [PTR_W-1:0]    ptr, owner, arb_win;
  logic [NUM_REQ-1:0]  arb_gnt, owner_oh;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [STRB_W-1:0]   cmd_strb;
  logic [BLEN_W-1:0]   cmd_blen, beat_cnt;
  logic                tmo_hit;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];
  logic [STRB_W-1:0]   strb_a  [NUM_REQ];
  logic [BLEN_W-1:0]   blen_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    assign strb_a[i]  = req_strb[i*STRB_W +: STRB_W];
    assign blen_a[i]  = req_blen[i*BLEN_W +: BLEN_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .win (arb_win)
  );

  assign owner_oh = NUM_REQ'(1) << owner;
  assign U_AWADDR = cmd_addr;
  assign U_ARADDR = cmd_addr;
  assign U_WDATA  = cmd_wdata;
  assign U_STRB   = cmd_strb;
  assign U_BLEN   = cmd_blen;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = tmo_cnt_w(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;

  // A beat or done in the limit cycle wins over the watchdog.
  assign tmo_hit = (state == WAIT) && !U_DONE && !U_RDATA_VALID &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET || state != WAIT || U_DONE || U_RDATA_VALID) tmo_cnt <= '0;
    else                                                    tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // Watchdog absent; TIMEOUT_CYC stays on the interface for drop-in compatibility.
  assign tmo_hit = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_grant = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_done  = '0;
    rsp_err   = 1'b0;
    U_WVALID  = 1'b0;
    U_RVALID  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_grant = arb_gnt;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        U_WVALID = cmd_write;
        U_RVALID = !cmd_write;
        state_n  = WAIT;
      end
      WAIT: begin
        if (cmd_write) begin
          if (U_DONE) begin
            rsp_done = owner_oh;
            state_n  = IDLE;
          end
        end else if (U_RDATA_VALID) begin
          rsp_valid = owner_oh;
          rsp_data  = U_RDATA;
          if (beat_cnt == cmd_blen) begin
            rsp_done = owner_oh;
            state_n  = IDLE;
          end
        end
        if (tmo_hit) begin
          rsp_done = owner_oh;
          rsp_err  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (ARESET) begin
      state_n   = IDLE;
      req_grant = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_done  = '0;
      rsp_err   = 1'b0;
      U_WVALID  = 1'b0;
      U_RVALID  = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ptr       <= '0;
      owner     <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_strb  <= '0;
      cmd_blen  <= '0;
      beat_cnt  <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        owner     <= arb_win;
        cmd_write <= req_write[arb_win];
        cmd_addr  <= addr_a[arb_win];
        cmd_wdata <= wdata_a[arb_win];
        cmd_strb  <= strb_a[arb_win];
        cmd_blen  <= blen_a[arb_win];
        ptr       <= (arb_win == PTR_W'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
      end
      if (state == ISSUE)
        beat_cnt <= '0;
      else if (state == WAIT && !cmd_write && U_RDATA_VALID)
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Self-checking bench for axi_user_arbiter; round-robin reference model plus directed and random scenarios.
module tb_axi_user_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*4-1:0]  req_blen;
  logic [N-1:0]    req_grant, rsp_valid, rsp_done;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err, U_WVALID, U_RVALID;
  logic [AW-1:0]   U_AWADDR, U_ARADDR;
  logic [DW-1:0]   U_WDATA, U_RDATA;
  logic [SW-1:0]   U_STRB;
  logic [3:0]      U_BLEN;
  logic            U_RDATA_VALID, U_DONE;

  logic [N+N+DW+N+3+AW+AW+DW+SW+4-1:0] all_out;
  assign all_out = {req_grant, rsp_valid, rsp_data, rsp_done, rsp_err, U_WVALID, U_RVALID,
                    U_AWADDR, U_ARADDR, U_WDATA, U_STRB, U_BLEN};

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  logic          m_write [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic [SW-1:0] m_strb  [N];
  logic [3:0]    m_blen  [N];

  always #5 ACLK = ~ACLK;

  axi_user_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_blen(req_blen),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_done(rsp_done), .rsp_err(rsp_err),
    .U_WVALID(U_WVALID), .U_RVALID(U_RVALID), .U_AWADDR(U_AWADDR), .U_ARADDR(U_ARADDR),
    .U_WDATA(U_WDATA), .U_STRB(U_STRB), .U_BLEN(U_BLEN),
    .U_RDATA(U_RDATA), .U_RDATA_VALID(U_RDATA_VALID), .U_DONE(U_DONE)
  );

  // Round-robin rule: first valid requester at or after the pointer, wrapping.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = '0; U_DONE = 1'b0; U_RDATA_VALID = 1'b0; U_RDATA = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [3:0] b);
    req_write[i] = w;  req_addr[i*AW +: AW] = a;  req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;  req_blen[i*4 +: 4] = b;
    m_write[i] = w; m_addr[i] = a; m_wdata[i] = d; m_strb[i] = s; m_blen[i] = b;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; idle_inputs();
    req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_blen = '0;
    tick(); tick();
    req_valid = '1; #1;
    checks++; if (req_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", req_grant); end
    req_valid = '0; #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    ARESET = 1'b0; mptr = 0;
    tick();
  endtask

  task automatic test_write_single;
    int w;
    set_req(0, 1'b1, 32'h0, 32'h1234_5678, 4'b0001, 4'd0);
    req_valid = 2'b01; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL wr_grant: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0; #1;
    checks++; if ({U_WVALID, U_RVALID} !== 2'b10) begin errors++; $display("FAIL wr_cmd_valid: got %b want 10", {U_WVALID, U_RVALID}); end
    checks++; if ({U_AWADDR, U_WDATA, U_STRB} !== {32'h0, 32'h1234_5678, 4'b0001}) begin
      errors++; $display("FAIL wr_cmd_fields: got %h %h %b", U_AWADDR, U_WDATA, U_STRB); end
    tick(); #1;
    checks++; if ({U_WVALID, rsp_done} !== 3'b000) begin errors++; $display("FAIL wr_wait_quiet: got %b want 000", {U_WVALID, rsp_done}); end
    tick(); U_DONE = 1'b1; #1;
    checks++; if ({rsp_done, rsp_err} !== {oh(w), 1'b0}) begin errors++; $display("FAIL wr_done: got %b want %b0", {rsp_done, rsp_err}, oh(w)); end
    tick(); U_DONE = 1'b0;
  endtask

  task automatic test_read_burst;
    int w;
    logic [DW-1:0] d;
    set_req(1, 1'b0, 32'h2, '0, '0, 4'd3);
    req_valid = 2'b10; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL rd_grant: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0; #1;
    checks++; if ({U_WVALID, U_RVALID, U_ARADDR, U_BLEN} !== {2'b01, 32'h2, 4'd3}) begin
      errors++; $display("FAIL rd_cmd: got %b%b %h %0d", U_WVALID, U_RVALID, U_ARADDR, U_BLEN); end
    tick();
    for (int b = 0; b < 4; b++) begin
      d = $urandom; U_RDATA = d; U_RDATA_VALID = 1'b1; #1;
      checks++; if ({rsp_valid, rsp_data, rsp_done} !== {oh(w), d, (b == 3) ? oh(w) : 2'b00}) begin
        errors++; $display("FAIL rd_beat%0d: got %b %h %b", b, rsp_valid, rsp_data, rsp_done); end
      tick(); U_RDATA_VALID = 1'b0;
      if (b < 3) begin
        #1;
        checks++; if ({rsp_valid, rsp_done} !== 4'b0) begin errors++; $display("FAIL rd_gap%0d: got %b want 0", b, {rsp_valid, rsp_done}); end
        tick();
      end
    end
  endtask

  task automatic test_alternate;
    int w;
    set_req(0, 1'b1, 32'h100, 32'hA0, 4'hF, 4'd0);
    set_req(1, 1'b1, 32'h200, 32'hB1, 4'hF, 4'd0);
    req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      #1;
      w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
      checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL alt_grant%0d: got %b want %b", t, req_grant, oh(w)); end
      tick(); #1;
      checks++; if ({U_WVALID, U_AWADDR, req_grant} !== {1'b1, m_addr[w], 2'b00}) begin
        errors++; $display("FAIL alt_issue%0d: got %b %h %b", t, U_WVALID, U_AWADDR, req_grant); end
      tick(); U_DONE = 1'b1; #1;
      checks++; if (rsp_done !== oh(w)) begin errors++; $display("FAIL alt_done%0d: got %b want %b", t, rsp_done, oh(w)); end
      tick(); U_DONE = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_queue_wait;
    int w;
    set_req(0, 1'b1, 32'h300, 32'hC3, 4'h3, 4'd0);
    req_valid = 2'b01; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL q_grant0: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0;
    tick();
    set_req(1, 1'b0, 32'h44, '0, '0, 4'd0);
    req_valid = 2'b10;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_grant !== '0) begin errors++; $display("FAIL q_hold%0d: got %b want 00", c, req_grant); end
      tick();
    end
    U_DONE = 1'b1; #1;
    checks++; if ({rsp_done, req_grant} !== {oh(w), 2'b00}) begin errors++; $display("FAIL q_done: got %b want %b00", {rsp_done, req_grant}, oh(w)); end
    tick(); U_DONE = 1'b0; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL q_grant1: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0; #1;
    checks++; if ({U_RVALID, U_ARADDR} !== {1'b1, 32'h44}) begin errors++; $display("FAIL q_issue1: got %b %h", U_RVALID, U_ARADDR); end
    tick(); U_RDATA = 32'hFEED_0001; U_RDATA_VALID = 1'b1; #1;
    checks++; if ({rsp_valid, rsp_done, rsp_data} !== {oh(w), oh(w), 32'hFEED_0001}) begin
      errors++; $display("FAIL q_beat: got %b %b %h", rsp_valid, rsp_done, rsp_data); end
    tick(); U_RDATA_VALID = 1'b0;
  endtask

  task automatic test_reset_mid;
    int w;
    set_req(1, 1'b0, 32'h80, '0, '0, 4'd3);
    req_valid = 2'b10; #1;
    w = rr_pick(mptr, req_valid);
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL rm_grant: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0;
    tick();
    for (int b = 0; b < 2; b++) begin
      U_RDATA = 32'h5A5A_0000 + b; U_RDATA_VALID = 1'b1; #1;
      checks++; if ({rsp_valid, rsp_done} !== {oh(w), 2'b00}) begin errors++; $display("FAIL rm_beat%0d: got %b", b, {rsp_valid, rsp_done}); end
      tick();
    end
    ARESET = 1'b1; U_RDATA_VALID = 1'b1;
    tick();
    ARESET = 1'b0; mptr = 0; #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rm_cleared: got %h want 0", all_out); end
    tick(); U_RDATA_VALID = 1'b0;
    set_req(1, 1'b1, 32'h90, 32'h77, 4'h1, 4'd0);
    req_valid = 2'b10; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL rm_regrant: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0; #1;
    checks++; if ({U_WVALID, U_AWADDR} !== {1'b1, 32'h90}) begin errors++; $display("FAIL rm_issue: got %b %h", U_WVALID, U_AWADDR); end
    tick(); U_DONE = 1'b1; #1;
    checks++; if (rsp_done !== oh(w)) begin errors++; $display("FAIL rm_done: got %b want %b", rsp_done, oh(w)); end
    tick(); U_DONE = 1'b0;
  endtask

  task automatic test_timeout;
    int w;
    set_req(0, 1'b1, 32'hDEAD, 32'h1, 4'h1, 4'd0);
    req_valid = 2'b01; #1;
    w = rr_pick(mptr, req_valid); mptr = (w + 1) % N;
    checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL to_grant: got %b want %b", req_grant, oh(w)); end
    tick(); req_valid = '0;
    tick();
`ifdef AXI_ARB_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      #1;
      checks++; if ({rsp_done, rsp_err} !== ((c == TMO) ? {oh(w), 1'b1} : 3'b000)) begin
        errors++; $display("FAIL to_cycle%0d: got %b", c, {rsp_done, rsp_err}); end
      tick();
    end
    U_DONE = 1'b1; #1;
    checks++; if (rsp_done !== '0) begin errors++; $display("FAIL to_stray_done: got %b want 00", rsp_done); end
    tick(); U_DONE = 1'b0;
`else
    for (int c = 1; c <= 3 * TMO; c++) begin
      #1;
      checks++; if ({rsp_done, rsp_err} !== 3'b000) begin errors++; $display("FAIL to_nowd%0d: got %b", c, {rsp_done, rsp_err}); end
      tick();
    end
    U_DONE = 1'b1; #1;
    checks++; if ({rsp_done, rsp_err} !== {oh(w), 1'b0}) begin errors++; $display("FAIL to_late_done: got %b", {rsp_done, rsp_err}); end
    tick(); U_DONE = 1'b0;
`endif
  endtask

  task automatic test_random;
    int w;
    logic [N-1:0]  mask;
    logic [DW-1:0] d;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom), $urandom, $urandom, SW'($urandom), 4'($urandom_range(0, 3)));
      mask = N'($urandom_range(1, 3));
      req_valid = mask; #1;
      w = rr_pick(mptr, mask); mptr = (w + 1) % N;
      checks++; if (req_grant !== oh(w)) begin errors++; $display("FAIL rnd_grant%0d: got %b want %b", t, req_grant, oh(w)); end
      tick(); req_valid = N'($urandom); #1;
      checks++; if ({U_WVALID, U_RVALID, req_grant} !== {m_write[w], !m_write[w], 2'b00}) begin
        errors++; $display("FAIL rnd_issue%0d: got %b%b %b", t, U_WVALID, U_RVALID, req_grant); end
      checks++; if ({U_AWADDR, U_ARADDR, U_WDATA, U_STRB, U_BLEN} !== {m_addr[w], m_addr[w], m_wdata[w], m_strb[w], m_blen[w]}) begin
        errors++; $display("FAIL rnd_fields%0d: got %h %h %h %h %h", t, U_AWADDR, U_ARADDR, U_WDATA, U_STRB, U_BLEN); end
      tick(); req_valid = '0;
      if (m_write[w]) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          U_RDATA_VALID = 1'($urandom); #1;
          checks++; if ({rsp_valid, rsp_done} !== 4'b0) begin errors++; $display("FAIL rnd_wgap%0d: got %b", t, {rsp_valid, rsp_done}); end
          tick();
        end
        U_RDATA_VALID = 1'b0; U_DONE = 1'b1; #1;
        checks++; if ({rsp_valid, rsp_done, rsp_err} !== {2'b00, oh(w), 1'b0}) begin
          errors++; $display("FAIL rnd_wdone%0d: got %b", t, {rsp_valid, rsp_done, rsp_err}); end
        tick(); U_DONE = 1'b0;
      end else begin
        for (int b = 0; b <= int'(m_blen[w]); b++) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            #1;
            checks++; if ({rsp_valid, rsp_done} !== 4'b0) begin errors++; $display("FAIL rnd_rgap%0d: got %b", t, {rsp_valid, rsp_done}); end
            tick();
          end
          d = $urandom; U_RDATA = d; U_RDATA_VALID = 1'b1; #1;
          checks++; if ({rsp_valid, rsp_data, rsp_done} !== {oh(w), d, (b == int'(m_blen[w])) ? oh(w) : 2'b00}) begin
            errors++; $display("FAIL rnd_beat%0d_%0d: got %b %h %b", t, b, rsp_valid, rsp_data, rsp_done); end
          tick(); U_RDATA_VALID = 1'b0;
        end
      end
      U_DONE = 1'b1; U_RDATA_VALID = 1'b1; #1;
      checks++; if ({rsp_valid, rsp_done, req_grant} !== 6'b0) begin
        errors++; $display("FAIL rnd_idle_ignore%0d: got %b", t, {rsp_valid, rsp_done, req_grant}); end
      tick(); U_DONE = 1'b0; U_RDATA_VALID = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_alternate();
    test_queue_wait();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
